// File: rtl/fp_mul_sched_if.sv
// Request, shared-multiplier and response signals of the FP multiply scheduler.
// The scheduler uses the slave modport; the requesters, multiplier and consumer use master.
interface fp_mul_sched_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic        req0_ready;
    logic        req1_ready;
    logic        mul_start;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        mul_overflow;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_overflow;
    logic        resp_timeout;
    logic        resp_ready;

    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        output mul_result, mul_done, mul_overflow, resp_ready,
        input  req0_ready, req1_ready, mul_start, mul_op1, mul_op2,
        input  resp_valid, resp_id, resp_result, resp_overflow, resp_timeout
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        input  mul_result, mul_done, mul_overflow, resp_ready,
        output req0_ready, req1_ready, mul_start, mul_op1, mul_op2,
        output resp_valid, resp_id, resp_result, resp_overflow, resp_timeout
    );
endinterface

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one FP multiplier between two requesters,
// one operation in flight, with a WAIT-state timeout on the multiplier.
module fp_mul_sched #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    fp_mul_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mul_start_q, mul_start_d;
    logic [31:0] mul_op1_q, mul_op1_d;
    logic [31:0] mul_op2_q, mul_op2_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_result_q, resp_result_d;
    logic        resp_overflow_q, resp_overflow_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic        grant0, grant1;

    // Tie goes to whichever requester was not served last; ready is held low while reset is asserted.
    always_comb begin
        grant0 = (state_q == IDLE) && !rst && bus.req0_valid && (!bus.req1_valid || last_q);
        grant1 = (state_q == IDLE) && !rst && bus.req1_valid && !grant0;
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        mul_start_d     = 1'b0;
        mul_op1_d       = mul_op1_q;
        mul_op2_d       = mul_op2_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_result_d   = resp_result_q;
        resp_overflow_d = resp_overflow_q;
        resp_timeout_d  = resp_timeout_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d     = ISSUE;
                    mul_start_d = 1'b1;
                    mul_op1_d   = grant1 ? bus.req1_op1 : bus.req0_op1;
                    mul_op2_d   = grant1 ? bus.req1_op2 : bus.req0_op2;
                    resp_id_d   = grant1;
                    last_d      = grant1;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    resp_result_d   = bus.mul_result;
                    resp_overflow_d = bus.mul_overflow;
                    resp_timeout_d  = 1'b0;
                    resp_valid_d    = 1'b1;
                    state_d         = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_result_d   = 32'd0;
                    resp_overflow_d = 1'b0;
                    resp_timeout_d  = 1'b1;
                    resp_valid_d    = 1'b1;
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            last_q          <= 1'b1;
            cnt_q           <= 8'd0;
            mul_start_q     <= 1'b0;
            mul_op1_q       <= 32'd0;
            mul_op2_q       <= 32'd0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_result_q   <= 32'd0;
            resp_overflow_q <= 1'b0;
            resp_timeout_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            cnt_q           <= cnt_d;
            mul_start_q     <= mul_start_d;
            mul_op1_q       <= mul_op1_d;
            mul_op2_q       <= mul_op2_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_result_q   <= resp_result_d;
            resp_overflow_q <= resp_overflow_d;
            resp_timeout_q  <= resp_timeout_d;
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.mul_start     = mul_start_q;
    assign bus.mul_op1       = mul_op1_q;
    assign bus.mul_op2       = mul_op2_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_overflow = resp_overflow_q;
    assign bus.resp_timeout  = resp_timeout_q;
endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched: transaction-timeline reference model with randomized
// requesters, multiplier latency and consumer back-pressure.
module tb_fp_mul_sched;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_sched_if bus();
    fp_mul_sched #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending requests, round-robin pointer and the timeline of the
    // operation in flight measured in cycles since acceptance (acceptance cycle = 0).
    bit          pend [2];
    logic [31:0] p_op1 [2];
    logic [31:0] p_op2 [2];
    bit          last;
    bit          busy;
    int          t, done_at, resp_at;
    bit          e_id, e_ovf, e_to;
    logic [31:0] e_op1, e_op2, e_res;
    int          rdy_hold;
    int          n_resp;
    logic [31:0] obs_res;
    bit          obs_ovf, obs_to, obs_id;
    int          k_gen, k_fix, k_d, k_ovf, k_rdy, k_spur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_d();
        int r;
        if (k_d >= 0) return k_d;
        r = int'($urandom_range(0, 7));
        case (r)
            0, 1, 2: return 1;
            3:       return 2;
            4:       return 3;
            5:       return TMO;
            6:       return TMO + 1;
            default: return 0;
        endcase
    endfunction

    task automatic cycle();
        int w, d;
        logic [31:0] r;
        bit od, ov, rr, in_wait, rv;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            if (!pend[n] && int'($urandom_range(0, 99)) < k_gen) begin
                pend[n] = 1'b1;
                if (k_fix != 0) begin
                    p_op1[n] = (n == 0) ? 32'h40000000 : 32'h3FA00000;
                    p_op2[n] = (n == 0) ? 32'h40400000 : 32'h3FC00000;
                end else begin
                    p_op1[n] = $urandom;
                    p_op2[n] = $urandom;
                end
            end
        end
        if (e_op1 == 32'h40000000 && e_op2 == 32'h40400000)      r = 32'h40C00000;
        else if (e_op1 == 32'h3FA00000 && e_op2 == 32'h3FC00000) r = 32'h3FF00000;
        else                                                     r = $urandom;
        ov = (k_ovf < 0) ? 1'($urandom_range(0, 1)) : 1'(k_ovf);
        in_wait = busy && t >= 2 && t < resp_at;
        if (busy && t == done_at) od = 1'b1;
        else if (in_wait)         od = 1'b0;
        else                      od = (int'($urandom_range(0, 99)) < k_spur);
        rr = (rdy_hold > 0) ? 1'b0 : (int'($urandom_range(0, 99)) < k_rdy);
        bus.req0_valid   = pend[0];
        bus.req0_op1     = p_op1[0];
        bus.req0_op2     = p_op2[0];
        bus.req1_valid   = pend[1];
        bus.req1_op1     = p_op1[1];
        bus.req1_op2     = p_op2[1];
        bus.mul_done     = od;
        bus.mul_result   = r;
        bus.mul_overflow = ov;
        bus.resp_ready   = rr;
        #1;
        w = -1;
        if (!busy) begin
            if (pend[0] && (!pend[1] || last)) w = 0;
            else if (pend[1])                  w = 1;
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(w == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
        chk("mul_start", 32'(bus.mul_start), 32'(busy && t == 1));
        if (busy) begin
            chk("mul_op1", bus.mul_op1, e_op1);
            chk("mul_op2", bus.mul_op2, e_op2);
        end
        rv = busy && t >= resp_at;
        chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
        if (rv) begin
            chk("resp_id", 32'(bus.resp_id), 32'(e_id));
            chk("resp_result", bus.resp_result, e_res);
            chk("resp_overflow", 32'(bus.resp_overflow), 32'(e_ovf));
            chk("resp_timeout", 32'(bus.resp_timeout), 32'(e_to));
        end
        if (in_wait && od) begin
            e_res = r;
            e_ovf = ov;
            e_to  = 1'b0;
        end
        if (rv) begin
            if (rr) begin
                busy    = 1'b0;
                n_resp++;
                obs_res = bus.resp_result;
                obs_ovf = bus.resp_overflow;
                obs_to  = bus.resp_timeout;
                obs_id  = bus.resp_id;
            end else if (rdy_hold > 0) begin
                rdy_hold--;
            end
        end else if (busy) begin
            t++;
        end
        if (w >= 0) begin
            busy    = 1'b1;
            t       = 1;
            e_id    = 1'(w);
            e_op1   = p_op1[w];
            e_op2   = p_op2[w];
            last    = 1'(w);
            pend[w] = 1'b0;
            d       = pick_d();
            done_at = (d == 0) ? -1 : d + 1;
            resp_at = (d == 0 || d > TMO) ? TMO + 2 : d + 2;
            if (d == 0 || d > TMO) begin
                e_res = 32'd0;
                e_ovf = 1'b0;
                e_to  = 1'b1;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
        chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
        chk({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
        chk({tag, "_mul_op1"}, bus.mul_op1, 32'd0);
        chk({tag, "_mul_op2"}, bus.mul_op2, 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        chk({tag, "_resp_result"}, bus.resp_result, 32'd0);
        chk({tag, "_resp_overflow"}, 32'(bus.resp_overflow), 32'd0);
        chk({tag, "_resp_timeout"}, 32'(bus.resp_timeout), 32'd0);
    endtask

    // Asynchronous reset pulse; a stray mul_done is presented as reset releases.
    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst            = 1'b0;
        busy           = 1'b0;
        last           = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.mul_done   = 1'b1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic drain();
        k_gen = 0; k_rdy = 100; rdy_hold = 0;
        for (int i = 0; i < 200 && (busy || pend[0] || pend[1]); i++) cycle();
        chk("drain_idle", 32'(busy || pend[0] || pend[1]), 32'd0);
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b);
        pend[0] = 1'b1; p_op1[0] = a; p_op2[0] = b;
    endtask

    int n0;

    initial begin
        pend[0] = 0; pend[1] = 0; last = 1; busy = 0; t = 0; done_at = -1; resp_at = 0;
        e_id = 0; e_ovf = 0; e_to = 0; e_op1 = 0; e_op2 = 0; e_res = 0; rdy_hold = 0; n_resp = 0;
        p_op1[0] = 0; p_op1[1] = 0; p_op2[0] = 0; p_op2[1] = 0;
        obs_res = 0; obs_ovf = 0; obs_to = 0; obs_id = 0;
        k_gen = 0; k_fix = 1; k_d = 1; k_ovf = 0; k_rdy = 100; k_spur = 0;
        rst = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_op1 = 0; bus.req0_op2 = 0;
        bus.req1_op1 = 0; bus.req1_op2 = 0; bus.mul_result = 0; bus.mul_done = 0;
        bus.mul_overflow = 0; bus.resp_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request, fastest multiplier: response three cycles after acceptance.
        set_req0(32'h3FA00000, 32'h3FC00000);
        n0 = n_resp;
        repeat (6) cycle();
        chk("basic_count", 32'(n_resp - n0), 32'd1);
        chk("basic_result", obs_res, 32'h3FF00000);
        chk("basic_id", 32'(obs_id), 32'd0);
        chk("basic_timeout", 32'(obs_to), 32'd0);

        // Both requesters continuously valid: grants alternate.
        k_gen = 100; k_fix = 1; n0 = n_resp;
        repeat (24) cycle();
        chk("rr_count", 32'(n_resp - n0 >= 5), 32'd1);
        drain();

        // Multiplier never answers: timeout, with late mul_done pulses ignored.
        k_d = 0; k_spur = 50;
        set_req0($urandom, $urandom);
        repeat (TMO + 6) cycle();
        chk("tmo_flag", 32'(obs_to), 32'd1);
        chk("tmo_result", obs_res, 32'd0);
        drain();
        k_d = TMO; set_req0($urandom, $urandom);
        repeat (TMO + 6) cycle();
        chk("tmo_edge_in", 32'(obs_to), 32'd0);
        k_d = TMO + 1; set_req0($urandom, $urandom);
        repeat (TMO + 6) cycle();
        chk("tmo_edge_out", 32'(obs_to), 32'd1);
        drain();

        // Consumer stalls 10 cycles in RESP while another request waits.
        k_d = 1; k_spur = 30; n0 = n_resp;
        set_req0(32'h40000000, 32'h40400000);
        pend[1] = 1; p_op1[1] = 32'h3FA00000; p_op2[1] = 32'h3FC00000;
        rdy_hold = 10;
        repeat (25) cycle();
        chk("hold_count", 32'(n_resp - n0), 32'd2);
        drain();

        // Reset in WAIT abandons the operation; the next request proceeds normally.
        k_d = 0; k_spur = 0; n0 = n_resp;
        set_req0($urandom, $urandom);
        for (int i = 0; i < 20 && !(busy && t == 5); i++) cycle();
        chk("rst_reached_wait", 32'(busy && t == 5), 32'd1);
        rst_pulse();
        chk("rst_no_resp", 32'(n_resp - n0), 32'd0);
        k_d = 1;
        set_req0(32'h3FA00000, 32'h3FC00000);
        repeat (6) cycle();
        chk("rst_after_count", 32'(n_resp - n0), 32'd1);
        chk("rst_after_id", 32'(obs_id), 32'd0);
        drain();

        // Overflow returned with mul_done.
        k_d = 2; k_ovf = 1;
        set_req0($urandom, $urandom);
        repeat (8) cycle();
        chk("ovf_flag", 32'(obs_ovf), 32'd1);
        chk("ovf_timeout", 32'(obs_to), 32'd0);
        drain();

        // Random traffic with occasional resets mid-operation.
        k_gen = 40; k_fix = 0; k_d = -1; k_ovf = -1; k_rdy = 70; k_spur = 30;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if ((i % 500) == 250 && busy && t >= 2 && t < resp_at) rst_pulse();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
